// File: rtl/avalon_pio_gen2.sv
// avalon_pio_gen2: parametrised Avalon-MM slave PIO with per-bit direction,
// synchronised inputs, edge capture with a maskable level interrupt and a
// registered read path.
// Optional build macro: PIO_BITSETCLR_EN adds write-only OUTSET (addr 4) and
// OUTCLEAR (addr 5) registers; without it those addresses are reserved.
module avalon_pio_gen2 #(
  parameter int               WIDTH      = 18,
  parameter int               EDGE_TYPE  = 0,
  parameter logic [WIDTH-1:0] DATA_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
`ifdef PIO_BITSETCLR_EN
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] capture_reg, capture_next;
  logic [WIDTH-1:0] sync1_reg, sync_reg, prev_reg;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] pin_value;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_reg, rd_mux;
  logic             irq_reg;
  logic [1:0]       guard_reg;
  logic             guard_done;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign wdata = writedata[WIDTH-1:0];
  // Upper write bits beyond WIDTH are deliberately discarded.
  assign unused_wdata = &{1'b0, writedata};

  assign guard_done = (guard_reg == 2'd3);
  assign clr_bits   = (wr_en && address == ADDR_CAPTURE) ? wdata : '0;

  // Per-bit edge detector selected at elaboration by EDGE_TYPE.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det[gi] = sync_reg[gi] & ~prev_reg[gi];
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det[gi] = ~sync_reg[gi] & prev_reg[gi];
    end else begin : g_any
      assign edge_det[gi] = sync_reg[gi] ^ prev_reg[gi];
    end
    // Output bits read back the driven value, input bits the synchronised pin.
    assign pin_value[gi] = dir_reg[gi] ? data_reg[gi] : sync_reg[gi];
  end

  // Output data register next value: DATA load plus optional set/clear.
  always_comb begin
    data_next = data_reg;
    if (wr_en && address == ADDR_DATA) data_next = wdata;
`ifdef PIO_BITSETCLR_EN
    if (wr_en && address == ADDR_OUTSET) data_next = data_reg | wdata;
    if (wr_en && address == ADDR_OUTCLR) data_next = data_reg & ~wdata;
`endif
  end

  // Capture is sticky; a new edge wins over a same-cycle W1C clear.
  always_comb begin
    capture_next = (capture_reg & ~clr_bits) | (edge_det & {WIDTH{guard_done}});
  end

  // Read mux; unused high bits and reserved addresses return zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = pin_value;
      ADDR_DIR:     rd_mux[WIDTH-1:0] = dir_reg;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = mask_reg;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0] = capture_reg;
      default:      rd_mux = '0;
    endcase
  end

  // Input synchroniser, delayed copy for edge detect, and post-reset guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync_reg  <= '0;
      prev_reg  <= '0;
      guard_reg <= 2'd0;
    end else begin
      sync1_reg <= in_port;
      sync_reg  <= sync1_reg;
      prev_reg  <= sync_reg;
      if (!guard_done) guard_reg <= guard_reg + 2'd1;
    end
  end

  // Control/status registers and registered interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= DATA_RESET;
      dir_reg     <= DIR_RESET;
      mask_reg    <= '0;
      capture_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      data_reg    <= data_next;
      capture_reg <= capture_next;
      irq_reg     <= |(capture_reg & mask_reg);
      if (wr_en && address == ADDR_DIR)  dir_reg  <= wdata;
      if (wr_en && address == ADDR_MASK) mask_reg <= wdata;
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg <= '0;
    end else if (rd_en) begin
      readdata_reg <= rd_mux;
    end
  end

  assign readdata = readdata_reg;
  assign out_port = data_reg;
  assign oe       = dir_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_avalon_pio_gen2.sv
// Scoreboard bench for avalon_pio_gen2 (default parameters, WIDTH=18).
module tb_avalon_pio_gen2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] in_port;
  logic [17:0] out_port;
  logic [17:0] oe;
  logic        irq;

  avalon_pio_gen2 dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe         (oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic rd_pend = 1'b0;

  // Read response is valid one cycle after the read strobe is sampled.
  always @(posedge clk) rd_pend <= chipselect && !read_n && !reset;

  // Monitor: pop the expected read data whenever a response is presented.
  always @(negedge clk) begin
    if (rd_pend) begin
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: got 0x%08h, nothing expected", readdata);
      end else begin
        e = exp_q.pop_front();
        if (readdata !== e.exp) begin
          n_err++;
          $display("FAIL %s: readdata 0x%08h expected 0x%08h", e.name, readdata, e.exp);
        end else begin
          $display("ok   %s: readdata 0x%08h", e.name, readdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
  endtask

  task automatic wr_start(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    read_n     = 1'b1;
    address    = a;
    writedata  = d;
    $display("write addr %0d data 0x%08h", a, d);
  endtask

  task automatic rd_start(input logic [2:0] a, input logic [31:0] exp, input string nm);
    exp_t e;
    chipselect = 1'b1;
    write_n    = 1'b1;
    read_n     = 1'b0;
    address    = a;
    e.exp      = exp;
    e.name     = nm;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_start(a, d);
    tick();
    idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
    rd_start(a, exp, nm);
    tick();
    idle();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    address   = 3'd0;
    writedata = 32'd0;
    in_port   = 18'd0;
    idle();
    repeat (3) tick();
    chk("reset_out_port", 32'(out_port), 32'h0);
    chk("reset_oe", 32'(oe), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset = 1'b0;

    // All registers read zero after reset with quiet pins.
    rd(3'd0, 32'h0, "rd_data_reset");
    rd(3'd1, 32'h0, "rd_dir_reset");
    rd(3'd2, 32'h0, "rd_mask_reset");
    rd(3'd3, 32'h0, "rd_cap_reset");
    rd(3'd6, 32'h0, "rd_reserved6");

    // Mixed direction read-back.
    wr(3'd1, 32'h0000F);
    wr(3'd0, 32'h3FFFF);
    in_port = 18'h2AAA0;
    repeat (3) tick();
    rd(3'd0, 32'h2AAAF, "data_mixed");
    chk("out_port_mixed", 32'(out_port), 32'h3FFFF);
    chk("oe_mixed", 32'(oe), 32'h0000F);
    rd(3'd3, 32'h2AAA0, "cap_data_edges");
    chk("irq_unmasked", 32'(irq), 32'h0);
    wr(3'd1, 32'hFFFF_FFFF);
    rd(3'd1, 32'h3FFFF, "dir_width");
    wr(3'd1, 32'h0000F);
    in_port = 18'h0;
    repeat (3) tick();
    wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd3, 32'h0, "cap_cleared");

    // Rising edge on bit 0: capture at k+2, irq at k+3.
    wr(3'd2, 32'h1);
    in_port[0] = 1'b1;
    tick();                           // edge k
    tick();                           // edge k+1
    rd_start(3'd3, 32'h0, "cap_before_k2");
    tick();                           // edge k+2
    idle();
    chk("irq_before_k3", 32'(irq), 32'h0);
    rd_start(3'd3, 32'h1, "cap_at_k2");
    tick();                           // edge k+3
    idle();
    chk("irq_at_k3", 32'(irq), 32'h1);

    // Capture stays set after the pin falls back.
    in_port[0] = 1'b0;
    repeat (4) tick();
    rd(3'd3, 32'h1, "cap_sticky");
    chk("irq_sticky", 32'(irq), 32'h1);

    // W1C clears; irq drops one edge after the clear lands.
    wr_start(3'd3, 32'h1);
    tick();
    idle();
    chk("irq_w1c_same", 32'(irq), 32'h1);
    tick();
    chk("irq_w1c_cleared", 32'(irq), 32'h0);

    // Same-cycle W1C and new edge on bit 2: set wins, bit 1 cleared.
    in_port[1] = 1'b1;
    repeat (4) tick();
    wr(3'd2, 32'h4);
    in_port[2] = 1'b1;
    tick();                           // edge k
    tick();                           // edge k+1
    wr_start(3'd3, 32'h6);
    tick();                           // edge k+2: clear and set together
    idle();
    tick();
    chk("irq_set_wins", 32'(irq), 32'h1);
    rd(3'd3, 32'h4, "cap_set_wins");

    // Masking drops irq next cycle but leaves capture alone.
    wr(3'd2, 32'h0);
    tick();
    chk("irq_masked", 32'(irq), 32'h0);
    rd(3'd3, 32'h4, "cap_after_mask");

    // Reset during a read forces readdata to zero.
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = 3'd3;
    reset      = 1'b1;
    tick();
    idle();
    chk("rd_during_reset", readdata, 32'h0);
    in_port = 18'h3FFFF;
    repeat (2) tick();
    chk("rst2_out_port", 32'(out_port), 32'h0);
    chk("rst2_oe", 32'(oe), 32'h0);
    chk("rst2_irq", 32'(irq), 32'h0);
    reset = 1'b0;

    // Pins high through reset must not be captured.
    repeat (10) tick();
    rd(3'd3, 32'h0, "cap_guard");
    rd(3'd0, 32'h3FFFF, "data_inputs");

    // Bit set/clear registers.
    wr(3'd0, 32'h000F0);
    wr(3'd4, 32'h00003);
    wr(3'd5, 32'h00010);
`ifdef PIO_BITSETCLR_EN
    chk("setclr_out_port", 32'(out_port), 32'h000E3);
`else
    chk("setclr_out_port", 32'(out_port), 32'h000F0);
`endif
    rd(3'd4, 32'h0, "rd_addr4");
    rd(3'd5, 32'h0, "rd_addr5");

    repeat (2) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_pio_gen2.md
Name: avalon_pio_gen2

Overview:
- Parametrised Avalon-MM slave PIO that replaces the fixed 18-bit output-only PIO.
- Provides:
  - per-bit direction control
  - synchronised inputs
  - edge capture with a maskable interrupt
  - a registered read path
- Sits on the Avalon-MM interconnect between the CPU data master and board GPIO such as LEDs, switches and keys.

Parameters:
- WIDTH, 18: number of PIO bits, legal range 1..32.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- DATA_RESET, 0: reset value of the output data register (WIDTH bits).
- DIR_RESET, 0: reset value of the direction register. 1 = output.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, valid 1 cycle after the read.
- in_port  in  WIDTH  asynchronous pin inputs.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable, equal to the direction register.
- irq  out  1  registered level interrupt.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high.
  - On reset: out_port=DATA_RESET, oe=DIR_RESET, mask=0, capture=0, irq=0, readdata=0, sync/prev flops=0.
- Register map (word addresses):
  - 0 DATA: write loads out_port. Read returns, per bit, out_port where oe=1, else the synchronised input.
  - 1 DIRECTION: R/W.
  - 2 IRQMASK: R/W.
  - 3 EDGECAPTURE: read returns capture bits. A write clears the bits where writedata=1 (W1C).
  - 4-7: reserved; read 0, writes ignored. Addresses 4 and 5 are reused when the optional feature is enabled.
- Write and read timing:
  - A write occurs when chipselect=1 and write_n=0. It takes effect at the next clk edge.
  - A read occurs when chipselect=1 and read_n=0. readdata is registered, so read latency is exactly 1 cycle.
  - When no read is in progress, readdata holds its last value.
- Width rules:
  - writedata[31:WIDTH] is ignored.
  - readdata[31:WIDTH] is always 0.
- Input path:
  - in_port goes through a 2-flop synchroniser to in_sync, then through one more flop to in_prev.
- Edge detect:
  - rise = in_sync & ~in_prev
  - fall = ~in_sync & in_prev
  - The bit selected by EDGE_TYPE sets the corresponding capture bit on the next edge.
- Latency: if in_port toggles before clk edge k:
  - in_sync updates at k+1.
  - The capture bit sets at k+2.
  - irq asserts at k+3 when the bit is masked in.
- irq is registered, computed as |(capture & mask).
- Post-reset guard:
  - A 2-bit counter blocks edge detection for the first 3 cycles after reset deasserts.
  - This prevents false captures from high pins at reset.
- Simultaneous events:
  - If a W1C write and a new edge hit the same bit in the same cycle, set wins and the bit stays 1.
  - Edges on other bits are unaffected by a clear.
- Sticky capture:
  - Capture bits remain set until cleared by W1C or reset, even after the pin returns to its prior level.
- Mask behaviour:
  - Changing IRQMASK affects irq on the next cycle.
  - Masking never clears capture.
- Input-only bits:
  - Writes to DATA for bits with oe=0 still update out_port.
  - The value drives the pin once the direction changes to output.
- Reset mid-operation:
  - A reset asserted during a read cycle forces readdata=0 on the next edge.
  - Pending captures are lost.

Optional Feature:
- Macro: PIO_BITSETCLR_EN.
- Defined:
  - Address 4 OUTSET: out_port |= writedata.
  - Address 5 OUTCLEAR: out_port &= ~writedata.
  - Both are write-only and read 0.
  - If a DATA write and a SET/CLR write occur in the same cycle, only one access is possible per cycle, so there is no conflict.
- Not defined:
  - Addresses 4 and 5 are reserved: they read 0 and writes are ignored.
  - No set/clear logic is synthesised.

Test Plan:
- Reset, then read all addresses 0-3 with in_port=0 → readdata=0. out_port=DATA_RESET. irq=0.
- Write DIRECTION=0x0000F, then DATA=0x3FFFF, with in_port=0x2AAA0 → next-cycle read of DATA returns 0x2AAAF. out_port=0x3FFFF.
- EDGE_TYPE=0, IRQMASK=0x1: in_port[0] goes 0→1 before edge k → capture=0x1 at k+2, irq=1 at k+3. Write 0x1 to addr 3 → irq=0 two cycles later.
- W1C write of bit 2 in the same cycle a new rising edge sets bit 2 → capture bit 2 reads 1. irq stays high if bit 2 is masked in.
- Hold in_port=0x3FFFF during reset, then release → capture stays 0 for 10 cycles (guard and no-edge check).
- With PIO_BITSETCLR_EN: DATA=0x00F0, OUTSET=0x0003, OUTCLEAR=0x0010 → out_port=0x00E3. Without the macro: the same writes leave out_port=0x00F0.
